prog_ctr_seq: RTL and testbench
===============================

Name: prog_ctr_seq

Overview:
Next-generation instruction-fetch program counter for the CSE141L core. Generalises the single-register PC to:
- N independently started programs at parametrised base addresses.
- Relative and absolute conditional branches.
- A hardware return-address stack for call/return.
- An explicit run/halt state machine with a Done indication to the test bench.
It drives the instruction-memory address and sits between the decoder/ALU flag outputs and instruction ROM.

Parameters:
A, 10, instruction address width in bits
NPROG, 3, number of programs selectable by Start pulses (1..8)
PROG_STRIDE, 100, base address of program k (k=0..NPROG-1) is k*PROG_STRIDE, truncated to A bits
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
Clk  in  1  clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  test-bench program request; level, edges detected internally
Branch  in  1  conditional branch instruction in current cycle
Bol  in  1  branch mode: 1 = absolute (PC<=Target), 0 = relative
Cond  in  1  branch condition from ALU flags; branch taken when Branch & Cond
Target  in  A  branch/call target or relative offset (two's complement when relative)
Call  in  1  call: push PC+1, PC<=Target
Ret  in  1  return: PC<=top of stack, pop
Halt  in  1  current instruction is halt
ProgCtr  out  A  program counter register
ProgIdx  out  3  index of the program currently loaded (0..NPROG-1)
Running  out  1  1 while state is RUN
Done  out  1  1 while state is HALTED
StackOvf  out  1  sticky: push attempted with stack full
StackUnf  out  1  sticky: pop attempted with stack empty

Behaviour:
- Reset: ProgCtr=0, ProgIdx=0, state IDLE, StartCount=0, start_r=0, stack pointer=0, StackOvf=StackUnf=0, Running=Done=0.
- Edge detection: start_r registers Start each cycle.
  - Rise: start_r=0 & Start=1. On rise, StartCount increments, saturating at NPROG+1.
  - Fall: start_r=1 & Start=0.
- States: IDLE, RUN, HALTED.
- Fall with 1<=StartCount<=NPROG, in any state:
  - Next cycle ProgCtr=(StartCount-1)*PROG_STRIDE and ProgIdx=StartCount-1.
  - State -> RUN; stack pointer cleared; StackOvf/StackUnf cleared.
- Fall with StartCount>NPROG: ignored; state unchanged.
- IDLE and HALTED: ProgCtr holds; all control inputs ignored.
- RUN, per cycle, by priority (first match wins):
  1. Start fall load (above).
  2. Halt: state -> HALTED; ProgCtr holds (points at the halt instruction).
  3. Ret:
     - Stack non-empty: ProgCtr<=stack[top], pop.
     - Stack empty: ProgCtr<=ProgCtr+1, StackUnf<=1.
  4. Call:
     - Stack not full: push ProgCtr+1, ProgCtr<=Target.
     - Stack full: push dropped, StackOvf<=1, ProgCtr<=Target (jump still taken).
  5. Branch & Cond:
     - Bol=1: ProgCtr<=Target.
     - Bol=0: ProgCtr<=ProgCtr+Target+1.
  6. Otherwise: ProgCtr<=ProgCtr+1.
- Arithmetic: all PC sums are A bits wide and wrap mod 2^A; no carry out. Example: A=10, PC=1023, increment -> 0.
- Branch with Cond=0: plain increment. Cond is 1 bit; the flag-to-condition decode happens upstream.
- Simultaneous Call and Ret: Ret wins; Call is ignored.
- Stack: LIFO indexed by pointer 0..STACK_DEPTH.
  - Full when pointer==STACK_DEPTH; empty when pointer==0.
  - Entries are not cleared on pop.
- Outputs: Running and Done are decoded from registered state. ProgCtr and ProgIdx are registers. Zero combinational path from inputs to outputs.
- Reset mid-run: next cycle equals the reset values. StartCount returns to 0, so the next Start selects program 0.
- Latency: every update is visible one cycle after the controlling edge. A Start fall at edge n makes ProgCtr=base after edge n+1.

Test Plan:
1. Reset, then Start 1 -> 0 three times, holding Halt after 5 increments each time.
   - Loads ProgCtr=0, 100, 200 and ProgIdx=0, 1, 2.
   - PC reaches base+5; Done=1; PC holds while halted.
   - A fourth Start pulse is ignored (Done stays 1).
2. In RUN at PC=50 with Target=10 (Bol=0, Branch=1):
   - Cond=1 -> PC=61.
   - Cond=0 -> PC=51.
   - Target=10'h3F6 (-10) from PC=50, relative, taken -> PC=41.
   - Bol=1, Target=7 -> PC=7.
3. PC=20, Call Target=300 -> PC=300. Then Call Target=400 -> PC=400. Then Ret -> 301. Ret -> 21.
   - StackOvf=StackUnf=0 throughout.
4. With STACK_DEPTH=4, perform 5 nested Calls.
   - 5th Call still jumps; StackOvf=1.
   - Then 5 Rets: the first 4 return correctly; the 5th gives PC+1 and StackUnf=1.
   - Next Start load clears both flags.
5. A=10, absolute branch to 1023 then increment -> PC=0. Call and Ret asserted together at PC=5 with stack top 30 -> PC=30.
6. Assert Reset mid-RUN at PC=137 with 2 stack entries.
   - Next cycle: PC=0, IDLE, stack empty.
   - Branch/Call inputs ignored until a Start fall, which loads program 0.

Source files
------------

// File: rtl/prog_ctr_seq.sv
// Instruction-fetch program counter with multi-program start, relative/absolute
// branches, a hardware return-address stack and an IDLE/RUN/HALTED controller.
module prog_ctr_seq #(
  parameter int A           = 10,
  parameter int NPROG       = 3,
  parameter int PROG_STRIDE = 100,
  parameter int STACK_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Branch,
  input  logic         Bol,
  input  logic         Cond,
  input  logic [A-1:0] Target,
  input  logic         Call,
  input  logic         Ret,
  input  logic         Halt,
  output logic [A-1:0] ProgCtr,
  output logic [2:0]   ProgIdx,
  output logic         Running,
  output logic         Done,
  output logic         StackOvf,
  output logic         StackUnf
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = 4;
  localparam logic [SW-1:0] CNT_MAX  = SW'(NPROG + 1);
  localparam logic [PW-1:0] SP_FULL  = PW'(STACK_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [2:0]    idx_q, idx_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic [PW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push;

  logic [A-1:0]  stack_mem [STACK_DEPTH];
  logic [A-1:0]  base_tbl [NPROG];
  logic [A-1:0]  ld_pc;
  logic [2:0]    ld_idx;
  logic          rise, fall, load;
  logic [A-1:0]  pc_inc, pc_rel, stack_top;

  // Program base addresses are elaboration-time constants, wrapped to A bits.
  generate
    for (genvar gi = 0; gi < NPROG; gi++) begin : g_base
      localparam int unsigned BASE_FULL = gi * PROG_STRIDE;
      assign base_tbl[gi] = BASE_FULL[A-1:0];
    end
  endgenerate

  assign rise      = ~start_q & Start;
  assign fall      = start_q & ~Start;
  assign load      = fall && (cnt_q != '0) && (cnt_q <= SW'(NPROG));
  assign pc_inc    = pc_q + A'(1);
  assign pc_rel    = pc_q + Target + A'(1);
  assign stack_top = stack_mem[IW'(sp_q - PW'(1))];

  always_comb begin
    ld_pc  = '0;
    ld_idx = '0;
    for (int k = 0; k < NPROG; k++) begin
      if (cnt_q == SW'(k + 1)) begin
        ld_pc  = base_tbl[k];
        ld_idx = 3'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    cnt_d   = (rise && cnt_q != CNT_MAX) ? cnt_q + SW'(1) : cnt_q;

    if (load) begin
      pc_d    = ld_pc;
      idx_d   = ld_idx;
      state_d = S_RUN;
      sp_d    = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (state_q == S_RUN) begin
      if (Halt) begin
        state_d = S_HALTED;
      end else if (Ret) begin
        if (sp_q != '0) begin
          pc_d = stack_top;
          sp_d = sp_q - PW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (Call) begin
        // A full stack drops the return address but the jump is still taken.
        pc_d = Target;
        if (sp_q != SP_FULL) begin
          push = 1'b1;
          sp_d = sp_q + PW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (Branch && Cond) begin
        pc_d = Bol ? Target : pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= Start;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      stack_mem[IW'(sp_q)] <= pc_inc;
    end
  end

  assign ProgCtr  = pc_q;
  assign ProgIdx  = idx_q;
  assign Running  = (state_q == S_RUN);
  assign Done     = (state_q == S_HALTED);
  assign StackOvf = ovf_q;
  assign StackUnf = unf_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed-vector bench for prog_ctr_seq: each record drives one cycle of inputs
// and gives the outputs expected after that clock edge.
module tb_prog_ctr_seq;

  localparam logic [7:0] RST = 8'h01, ST = 8'h02, BR = 8'h04, BOL = 8'h08;
  localparam logic [7:0] CND = 8'h10, CL = 8'h20, RT = 8'h40, HT = 8'h80;
  localparam logic [7:0] ABS = BR | BOL | CND;
  localparam logic [7:0] REL = BR | CND;
  localparam logic [3:0] R = 4'b1000, D = 4'b0100, O = 4'b0010, U = 4'b0001;

  typedef struct {
    logic [7:0] ctl;
    logic [9:0] tgt;
    logic [9:0] e_pc;
    logic [2:0] e_idx;
    logic [3:0] e_flags;
  } vec_t;

  logic       Clk, Reset, Start, Branch, Bol, Cond, Call, Ret, Halt;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic [2:0] ProgIdx;
  logic       Running, Done, StackOvf, StackUnf;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  prog_ctr_seq #(.A(10), .NPROG(3), .PROG_STRIDE(100), .STACK_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Bol(Bol),
    .Cond(Cond), .Target(Target), .Call(Call), .Ret(Ret), .Halt(Halt),
    .ProgCtr(ProgCtr), .ProgIdx(ProgIdx), .Running(Running), .Done(Done),
    .StackOvf(StackOvf), .StackUnf(StackUnf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic add(input logic [7:0] ctl, input int tgt, input int pc,
                     input int idx, input logic [3:0] flags);
    vec_t v;
    v.ctl = ctl; v.tgt = 10'(tgt); v.e_pc = 10'(pc); v.e_idx = 3'(idx);
    v.e_flags = flags;
    vecs.push_back(v);
  endtask

  task automatic step(input string name, input logic [7:0] ctl, input logic [9:0] tgt,
                      input logic [9:0] e_pc, input logic [2:0] e_idx,
                      input logic [3:0] e_flags);
    logic [3:0] got_flags;
    Reset = ctl[0]; Start = ctl[1]; Branch = ctl[2]; Bol = ctl[3];
    Cond = ctl[4]; Call = ctl[5]; Ret = ctl[6]; Halt = ctl[7]; Target = tgt;
    @(posedge Clk);
    #1;
    got_flags = {Running, Done, StackOvf, StackUnf};
    n_checks++;
    if (ProgCtr !== e_pc || ProgIdx !== e_idx || got_flags !== e_flags) begin
      n_errors++;
      $display("FAIL %s: got pc=%0d idx=%0d rdou=%b, expected pc=%0d idx=%0d rdou=%b",
               name, ProgCtr, ProgIdx, got_flags, e_pc, e_idx, e_flags);
    end else begin
      $display("pass %s: pc=%0d idx=%0d rdou=%b", name, ProgCtr, ProgIdx, got_flags);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Branch = 1'b0; Bol = 1'b0; Cond = 1'b0;
    Call = 1'b0; Ret = 1'b0; Halt = 1'b0; Target = '0;

    // Three program starts, each halted after five increments
    add(RST, 0, 0, 0, 4'b0);
    add(ST, 0, 0, 0, 4'b0);
    add(0, 0, 0, 0, R);
    add(0, 0, 1, 0, R); add(0, 0, 2, 0, R); add(0, 0, 3, 0, R);
    add(0, 0, 4, 0, R); add(0, 0, 5, 0, R);
    add(HT, 0, 5, 0, D);
    add(HT | ABS, 7, 5, 0, D);
    add(ST, 0, 5, 0, D);
    add(0, 0, 100, 1, R);
    add(0, 0, 101, 1, R); add(0, 0, 102, 1, R); add(0, 0, 103, 1, R);
    add(0, 0, 104, 1, R); add(0, 0, 105, 1, R);
    add(HT, 0, 105, 1, D);
    add(ST, 0, 105, 1, D);
    add(0, 0, 200, 2, R);
    add(0, 0, 201, 2, R); add(0, 0, 202, 2, R); add(0, 0, 203, 2, R);
    add(0, 0, 204, 2, R); add(0, 0, 205, 2, R);
    add(HT, 0, 205, 2, D);
    add(ST, 0, 205, 2, D);
    add(0, 0, 205, 2, D);
    // Branches
    add(RST, 0, 0, 0, 4'b0);
    add(ST, 0, 0, 0, 4'b0);
    add(0, 0, 0, 0, R);
    add(ABS, 50, 50, 0, R);
    add(REL, 10, 61, 0, R);
    add(ABS, 50, 50, 0, R);
    add(BR, 10, 51, 0, R);
    add(ABS, 50, 50, 0, R);
    add(REL, 10'h3F6, 41, 0, R);
    add(ABS, 7, 7, 0, R);
    // Call / return
    add(ABS, 20, 20, 0, R);
    add(CL, 300, 300, 0, R);
    add(CL, 400, 400, 0, R);
    add(RT, 0, 301, 0, R);
    add(RT, 0, 21, 0, R);
    // Overflow and underflow
    add(CL, 10, 10, 0, R); add(CL, 20, 20, 0, R);
    add(CL, 30, 30, 0, R); add(CL, 40, 40, 0, R);
    add(CL, 50, 50, 0, R | O);
    add(RT, 0, 31, 0, R | O); add(RT, 0, 21, 0, R | O);
    add(RT, 0, 11, 0, R | O); add(RT, 0, 22, 0, R | O);
    add(RT, 0, 23, 0, R | O | U);
    add(HT, 0, 23, 0, D | O | U);
    add(ST, 0, 23, 0, D | O | U);
    add(0, 0, 100, 1, R);
    // Wraparound and Call+Ret together
    add(ABS, 1023, 1023, 1, R);
    add(0, 0, 0, 1, R);
    add(ABS, 29, 29, 1, R);
    add(CL, 5, 5, 1, R);
    add(CL | RT, 77, 30, 1, R);
    add(RT, 0, 31, 1, R | U);
    // Reset mid-run
    add(CL, 135, 135, 1, R | U);
    add(CL, 137, 137, 1, R | U);
    add(RST | ABS, 300, 0, 0, 4'b0);
    add(ABS, 300, 0, 0, 4'b0);
    add(CL, 300, 0, 0, 4'b0);
    add(ST, 0, 0, 0, 4'b0);
    add(0, 0, 0, 0, R);
    add(RT, 0, 1, 0, R | U);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].tgt, vecs[i].e_pc,
           vecs[i].e_idx, vecs[i].e_flags);
    end

    // Priority corner cases: Halt beats Ret/Call, a Start fall beats Halt
    step("halt_on_rise", ST | HT, 10'd0, 10'd1, 3'd0, D | U);
    step("fall_beats_halt", HT | RT, 10'd0, 10'd100, 3'd1, R);
    step("halt_beats_ret_call", HT | RT | CL, 10'd9, 10'd100, 3'd1, D);
    step("halted_ignores_ret", RT, 10'd0, 10'd100, 3'd1, D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
